bus_tx_flow_queued: RTL and testbench

//  Next-generation I3C SDA transmit flow controller. It accepts variable-length bit-field requests
//  (1..DATA_W bits, MSB first), with an optional I3C odd-parity T-bit appended, through a

---
 rtl/bus_tx_flow_queued_if.sv | 39 +++
 rtl/bus_tx_flow_queued.sv | 162 ++++++++++++++++
 tb/tb_bus_tx_flow_queued.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_tx_flow_queued_if.sv
// Request/bus bundle for the I3C SDA transmit flow controller.
// slave: flow controller side; master: requester + bus_tx side.
`timescale 1ns/1ps
interface bus_tx_flow_queued_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = $clog2(DATA_W + 1)
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [DATA_W-1:0] req_data_i;
    logic [LEN_W-1:0]  req_len_i;
    logic              req_tbit_i;
    logic              abort_i;
    logic              drive_o;
    logic              drive_value_o;
    logic              tx_idle_i;
    logic              tx_done_i;
    logic              done_o;
    logic              req_error_o;
    logic              idle_o;
    logic [LVL_W-1:0]  fifo_level_o;

    modport slave (
        input  req_valid_i, req_data_i, req_len_i, req_tbit_i,
        input  abort_i, tx_idle_i, tx_done_i,
        output req_ready_o, drive_o, drive_value_o,
        output done_o, req_error_o, idle_o, fifo_level_o
    );

    modport master (
        output req_valid_i, req_data_i, req_len_i, req_tbit_i,
        output abort_i, tx_idle_i, tx_done_i,
        input  req_ready_o, drive_o, drive_value_o,
        input  done_o, req_error_o, idle_o, fifo_level_o
    );
endinterface

// File: rtl/bus_tx_flow_queued.sv
// I3C SDA transmit flow controller: queues 1..DATA_W-bit MSB-first
// requests (optional odd-parity T-bit) and feeds them gap-free to bus_tx.
// Ports: clk_i, rst_i (async high) and bus (slave modport of the bundle).
`timescale 1ns/1ps
module bus_tx_flow_queued #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = $clog2(DATA_W + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    bus_tx_flow_queued_if.slave   bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_TBIT} state_t;

    state_t state_q, state_d;

    // Reset asserts immediately, releases on a clock edge.
    logic [1:0] rst_pipe;
    logic       arst;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rst_pipe <= 2'b11;
        else       rst_pipe <= {rst_pipe[0], 1'b0};
    end

    assign arst = rst_pipe[1];

    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [LEN_W-1:0]  mem_len  [FIFO_DEPTH];
    logic              mem_tbit [FIFO_DEPTH];
    logic              mem_par  [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [LVL_W-1:0]  count_q;

    logic [DATA_W-1:0] shift_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              tbit_q, par_q;
    logic              done_q, err_q;

    logic full, empty, push, len_ok, store;
    logic pop, step, complete;
    logic [DATA_W-1:0] aligned, mask;

    assign full   = count_q == LVL_W'(FIFO_DEPTH);
    assign empty  = count_q == '0;
    assign len_ok = (bus.req_len_i != '0) && (bus.req_len_i <= MAX_LEN);
    assign push   = bus.req_valid_i & bus.req_ready_o;
    assign store  = push & len_ok;

    // Left-align so the first bit to send always sits at the MSB.
    assign aligned = bus.req_data_i << (MAX_LEN - bus.req_len_i);
    assign mask    = ~({DATA_W{1'b1}} << bus.req_len_i);

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        step     = 1'b0;
        complete = 1'b0;
        if (!bus.abort_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!empty && bus.tx_idle_i) begin
                        pop     = 1'b1;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bus.tx_done_i) begin
                        if (cnt_q != '0) step = 1'b1;
                        else if (tbit_q) state_d = S_TBIT;
                        else complete = 1'b1;
                    end
                end
                S_TBIT: begin
                    if (bus.tx_done_i) complete = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            // Reload in the completing cycle keeps SDA driven across requests.
            if (complete) begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tbit_q  <= 1'b0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_len[i]  <= '0;
                mem_tbit[i] <= 1'b0;
                mem_par[i]  <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= complete;
            err_q   <= push & ~len_ok;
            if (bus.abort_i) begin
                wr_q    <= '0;
                rd_q    <= '0;
                count_q <= '0;
            end else begin
                if (store) begin
                    mem_data[wr_q] <= aligned;
                    mem_len[wr_q]  <= bus.req_len_i;
                    mem_tbit[wr_q] <= bus.req_tbit_i;
                    mem_par[wr_q]  <= ~^(bus.req_data_i & mask);
                    wr_q           <= wr_q + AW'(1);
                end
                if (pop) rd_q <= rd_q + AW'(1);
                count_q <= count_q + LVL_W'(store) - LVL_W'(pop);
            end
            if (pop) begin
                shift_q <= mem_data[rd_q];
                cnt_q   <= mem_len[rd_q] - LEN_W'(1);
                tbit_q  <= mem_tbit[rd_q];
                par_q   <= mem_par[rd_q];
            end else if (step) begin
                shift_q <= shift_q << 1;
                cnt_q   <= cnt_q - LEN_W'(1);
            end
        end
    end

    always_comb begin
        bus.drive_value_o = 1'b1;
        unique case (state_q)
            S_SHIFT: bus.drive_value_o = shift_q[DATA_W-1];
            S_TBIT:  bus.drive_value_o = par_q;
            default: bus.drive_value_o = 1'b1;
        endcase
    end

    assign bus.drive_o      = state_q != S_IDLE;
    assign bus.req_ready_o  = ~full & ~bus.abort_i;
    assign bus.done_o       = done_q;
    assign bus.req_error_o  = err_q;
    assign bus.idle_o       = (state_q == S_IDLE) & empty & bus.tx_idle_i;
    assign bus.fifo_level_o = count_q;
endmodule

// File: tb/tb_bus_tx_flow_queued.sv
// Self-checking bench for bus_tx_flow_queued: directed scenarios plus a
// randomized run compared against a bit-stream model of the request queue.
`timescale 1ns/1ps
module tb_bus_tx_flow_queued;
    localparam int DATA_W = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    bus_tx_flow_queued_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) bus ();

    bus_tx_flow_queued #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] l, input logic t);
        int w = 0;
        bus.req_valid_i = 1'b1;
        bus.req_data_i = d;
        bus.req_len_i = l;
        bus.req_tbit_i = t;
        while (!bus.req_ready_o && w < 200) begin
            tick();
            w++;
        end
        vectors++;
        if (w >= 200) begin
            miscompares++;
            $display("FAIL push_timeout: ready low for %0d cycles, want accept", w);
        end
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    // Emulates bus_tx: waits for drive, samples the bit, pulses tx_done.
    task automatic serve(input int n, output logic [31:0] bits, output int nd,
                         output bit drop, output bit tmo);
        bits = '0;
        nd = 0;
        drop = 1'b0;
        tmo = 1'b0;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!bus.drive_o && w < 50) begin
                if (i > 0) drop = 1'b1;
                tick();
                nd += int'(bus.done_o);
                w++;
            end
            if (w >= 50) tmo = 1'b1;
            bits = {bits[30:0], bus.drive_value_o};
            repeat ($urandom_range(0, 2)) begin
                tick();
                nd += int'(bus.done_o);
                if (!bus.drive_o) drop = 1'b1;
            end
            bus.tx_done_i = 1'b1;
            tick();
            nd += int'(bus.done_o);
            bus.tx_done_i = 1'b0;
        end
        repeat (3) begin
            tick();
            nd += int'(bus.done_o);
        end
    endtask

    task automatic test_reset();
        bus.req_valid_i = 1'b0;
        bus.req_data_i = '0;
        bus.req_len_i = '0;
        bus.req_tbit_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.tx_idle_i = 1'b1;
        bus.tx_done_i = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        vectors++; if (bus.drive_o !== 1'b0) begin miscompares++; $display("FAIL rst_drive got %b want 0", bus.drive_o); end
        vectors++; if (bus.drive_value_o !== 1'b1) begin miscompares++; $display("FAIL rst_value got %b want 1", bus.drive_value_o); end
        vectors++; if (bus.done_o !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", bus.done_o); end
        vectors++; if (bus.req_error_o !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", bus.req_error_o); end
        vectors++; if (bus.fifo_level_o !== 3'd0) begin miscompares++; $display("FAIL rst_level got %0d want 0", bus.fifo_level_o); end
        vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", bus.req_ready_o); end
        rst = 1'b0;
        repeat (4) tick();
        vectors++; if (bus.idle_o !== 1'b1) begin miscompares++; $display("FAIL rst_idle got %b want 1", bus.idle_o); end
    endtask

    task automatic test_byte();
        logic [31:0] bits;
        int nd;
        bit drop, tmo;
        push(8'hA5, 4'd8, 1'b0);
        serve(8, bits, nd, drop, tmo);
        vectors++; if (bits[7:0] !== 8'hA5 || tmo) begin miscompares++; $display("FAIL byte_bits got %h tmo=%b want a5", bits[7:0], tmo); end
        vectors++; if (nd !== 1) begin miscompares++; $display("FAIL byte_done got %0d want 1", nd); end
        vectors++; if (bus.drive_o !== 1'b0 || bus.idle_o !== 1'b1) begin miscompares++; $display("FAIL byte_idle got drive=%b idle=%b want 0/1", bus.drive_o, bus.idle_o); end
    endtask

    task automatic test_tbit();
        logic [31:0] bits;
        int nd;
        bit drop, tmo;
        push(8'b110, 4'd3, 1'b1);
        serve(4, bits, nd, drop, tmo);
        vectors++; if (bits[3:0] !== 4'b1101 || tmo) begin miscompares++; $display("FAIL tbit_bits got %b want 1101", bits[3:0]); end
        vectors++; if (nd !== 1) begin miscompares++; $display("FAIL tbit_done got %0d want 1", nd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bits;
        int nd;
        bit drop, tmo;
        bus.tx_idle_i = 1'b0;
        push(8'b10, 4'd2, 1'b0);
        push(8'b01, 4'd2, 1'b0);
        vectors++; if (bus.fifo_level_o !== 3'd2) begin miscompares++; $display("FAIL b2b_level2 got %0d want 2", bus.fifo_level_o); end
        bus.tx_idle_i = 1'b1;
        tick();
        vectors++; if (bus.fifo_level_o !== 3'd1 || bus.drive_o !== 1'b1) begin miscompares++; $display("FAIL b2b_level1 got %0d drive=%b want 1/1", bus.fifo_level_o, bus.drive_o); end
        serve(4, bits, nd, drop, tmo);
        vectors++; if (bits[3:0] !== 4'b1001 || tmo) begin miscompares++; $display("FAIL b2b_bits got %b want 1001", bits[3:0]); end
        vectors++; if (drop) begin miscompares++; $display("FAIL b2b_gap got drop=1 want 0"); end
        vectors++; if (nd !== 2 || bus.fifo_level_o !== 3'd0) begin miscompares++; $display("FAIL b2b_done got %0d level=%0d want 2/0", nd, bus.fifo_level_o); end
    endtask

    task automatic test_full();
        logic [31:0] bits;
        logic [4:0] exp;
        logic [7:0] d;
        int nd;
        bit drop, tmo;
        bus.tx_idle_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            exp[4-i] = d[0];
            push(d, 4'd1, 1'b0);
        end
        vectors++; if (bus.req_ready_o !== 1'b0 || bus.fifo_level_o !== 3'd4) begin miscompares++; $display("FAIL full_state got ready=%b level=%0d want 0/4", bus.req_ready_o, bus.fifo_level_o); end
        d = 8'($urandom);
        exp[0] = d[0];
        bus.req_valid_i = 1'b1;
        bus.req_data_i = d;
        bus.req_len_i = 4'd1;
        bus.req_tbit_i = 1'b0;
        repeat (3) tick();
        vectors++; if (bus.fifo_level_o !== 3'd4) begin miscompares++; $display("FAIL full_hold got %0d want 4", bus.fifo_level_o); end
        bus.tx_idle_i = 1'b1;
        tick();
        vectors++; if (bus.fifo_level_o !== 3'd3 || bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_nopass got level=%0d ready=%b want 3/1", bus.fifo_level_o, bus.req_ready_o); end
        tick();
        bus.req_valid_i = 1'b0;
        vectors++; if (bus.fifo_level_o !== 3'd4) begin miscompares++; $display("FAIL full_refill got %0d want 4", bus.fifo_level_o); end
        serve(5, bits, nd, drop, tmo);
        vectors++; if (bits[4:0] !== exp || tmo) begin miscompares++; $display("FAIL full_bits got %b want %b", bits[4:0], exp); end
        vectors++; if (nd !== 5 || drop) begin miscompares++; $display("FAIL full_done got %0d drop=%b want 5/0", nd, drop); end
    endtask

    task automatic test_bad_len();
        bus.req_valid_i = 1'b1;
        bus.req_data_i = 8'hFF;
        bus.req_tbit_i = 1'b0;
        bus.req_len_i = 4'd0;
        tick();
        vectors++; if (bus.req_error_o !== 1'b1) begin miscompares++; $display("FAIL err_len0 got %b want 1", bus.req_error_o); end
        bus.req_len_i = 4'd9;
        tick();
        vectors++; if (bus.req_error_o !== 1'b1) begin miscompares++; $display("FAIL err_len9 got %b want 1", bus.req_error_o); end
        bus.req_valid_i = 1'b0;
        tick();
        vectors++; if (bus.req_error_o !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", bus.req_error_o); end
        vectors++; if (bus.fifo_level_o !== 3'd0 || bus.drive_o !== 1'b0) begin miscompares++; $display("FAIL err_nostore got level=%0d drive=%b want 0/0", bus.fifo_level_o, bus.drive_o); end
    endtask

    task automatic test_abort();
        int nd = 0;
        bus.tx_idle_i = 1'b0;
        for (int i = 0; i < 4; i++) push(8'($urandom), 4'd8, 1'b0);
        bus.tx_idle_i = 1'b1;
        tick();
        vectors++; if (bus.fifo_level_o !== 3'd3 || bus.drive_o !== 1'b1) begin miscompares++; $display("FAIL abort_start got level=%0d drive=%b want 3/1", bus.fifo_level_o, bus.drive_o); end
        repeat (3) begin
            bus.tx_done_i = 1'b1;
            tick();
            nd += int'(bus.done_o);
            bus.tx_done_i = 1'b0;
        end
        bus.abort_i = 1'b1;
        bus.tx_done_i = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_len_i = 4'd8;
        #1;
        vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b want 0", bus.req_ready_o); end
        tick();
        bus.abort_i = 1'b0;
        bus.tx_done_i = 1'b0;
        bus.req_valid_i = 1'b0;
        vectors++; if (bus.drive_o !== 1'b0 || bus.drive_value_o !== 1'b1) begin miscompares++; $display("FAIL abort_release got drive=%b value=%b want 0/1", bus.drive_o, bus.drive_value_o); end
        vectors++; if (bus.fifo_level_o !== 3'd0) begin miscompares++; $display("FAIL abort_flush got %0d want 0", bus.fifo_level_o); end
        nd += int'(bus.done_o);
        repeat (4) begin
            tick();
            nd += int'(bus.done_o);
        end
        vectors++; if (nd !== 0 || bus.idle_o !== 1'b1) begin miscompares++; $display("FAIL abort_nodone got done=%0d idle=%b want 0/1", nd, bus.idle_o); end
        push(8'h01, 4'd1, 1'b0);
        tick();
        bus.abort_i = 1'b1;
        bus.tx_done_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        bus.tx_done_i = 1'b0;
        nd = int'(bus.done_o);
        repeat (3) begin
            tick();
            nd += int'(bus.done_o);
        end
        vectors++; if (nd !== 0 || bus.drive_o !== 1'b0) begin miscompares++; $display("FAIL abort_wins got done=%0d drive=%b want 0/0", nd, bus.drive_o); end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        push(8'hFF, 4'd8, 1'b0);
        tick();
        vectors++; if (bus.drive_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_run got %b want 1", bus.drive_o); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.drive_o !== 1'b0 || bus.drive_value_o !== 1'b1 || bus.fifo_level_o !== 3'd0) begin miscompares++; $display("FAIL rstmid_out got drive=%b value=%b level=%0d want 0/1/0", bus.drive_o, bus.drive_value_o, bus.fifo_level_o); end
        tick();
        rst = 1'b0;
        repeat (5) begin
            tick();
            nd += int'(bus.done_o);
        end
        vectors++; if (nd !== 0) begin miscompares++; $display("FAIL rstmid_done got %0d want 0", nd); end
    endtask

    task automatic test_random();
        bit exp_q[$];
        bit obs_q[$];
        logic [7:0] rd [40];
        logic [3:0] rl [40];
        logic rt [40];
        int nlegal = 0, nillegal = 0, nd = 0, nerr = 0, nbad = 0;
        bit prod_done = 1'b0;
        int cyc = 0;
        for (int i = 0; i < 40; i++) begin
            int ones = 0;
            rd[i] = 8'($urandom);
            rl[i] = 4'($urandom_range(0, 10));
            rt[i] = 1'($urandom);
            if (rl[i] >= 1 && rl[i] <= 8) begin
                nlegal++;
                for (int b = int'(rl[i]) - 1; b >= 0; b--) begin
                    exp_q.push_back(rd[i][b]);
                    ones += int'(rd[i][b]);
                end
                if (rt[i]) exp_q.push_back(ones % 2 == 0);
            end else begin
                nillegal++;
            end
        end
        bus.tx_idle_i = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    push(rd[i], rl[i], rt[i]);
                end
                prod_done = 1'b1;
            end
            begin
                int wc = $urandom_range(0, 2);
                while ((obs_q.size() < exp_q.size() || !prod_done) && cyc < 20000) begin
                    tick();
                    cyc++;
                    nd += int'(bus.done_o);
                    nerr += int'(bus.req_error_o);
                    bus.tx_done_i = 1'b0;
                    if (bus.drive_o) begin
                        if (wc == 0) begin
                            obs_q.push_back(bus.drive_value_o);
                            bus.tx_done_i = 1'b1;
                            wc = $urandom_range(0, 2);
                        end else begin
                            wc--;
                        end
                    end
                end
                tick();
                bus.tx_done_i = 1'b0;
                nd += int'(bus.done_o);
                nerr += int'(bus.req_error_o);
                repeat (3) begin
                    tick();
                    nd += int'(bus.done_o);
                    nerr += int'(bus.req_error_o);
                end
            end
        join
        vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand_count got %0d bits want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) nbad++;
        vectors++; if (nbad !== 0) begin miscompares++; $display("FAIL rand_bits got %0d wrong bits want 0", nbad); end
        vectors++; if (nd !== nlegal) begin miscompares++; $display("FAIL rand_done got %0d want %0d", nd, nlegal); end
        vectors++; if (nerr !== nillegal) begin miscompares++; $display("FAIL rand_err got %0d want %0d", nerr, nillegal); end
        vectors++; if (bus.idle_o !== 1'b1) begin miscompares++; $display("FAIL rand_idle got %b want 1", bus.idle_o); end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_tbit();
        test_back_to_back();
        test_full();
        test_bad_len();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
